core_sequencer: RTL

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer_if.sv | 29 ++
 rtl/core_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Shared memory port between the core sequencer and the memory subsystem.
//   mem_read_enable  : read strobe (instruction fetch or load)
//   mem_write_enable : write strobe (store)
//   ifetch_select    : 1 = address from PC, 0 = address from alu_result
//   mem_ready        : memory finished the current access this cycle
// master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface core_sequencer_if;
  logic mem_read_enable;
  logic mem_write_enable;
  logic ifetch_select;
  logic mem_ready;

  modport master (
    output mem_read_enable,
    output mem_write_enable,
    output ifetch_select,
    input  mem_ready
  );

  modport slave (
    input  mem_read_enable,
    input  mem_write_enable,
    input  ifetch_select,
    output mem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the x32 datapath. Sequences fetch, decode,
// execute, memory access and writeback over one shared memory port, with
// free-running (run_enable) and single-step (step_pulse) control.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   run_enable          : level, execute instructions back to back
//   step_pulse          : one-cycle pulse, starts one instruction from IDLE
//   is_load/is_store/is_jump : decoded instruction class, valid from DECODE
//   mem                 : memory port (strobes, address select, mem_ready)
//   ir_load             : instruction register capture strobe
//   pc_enable           : PC advance/jump strobe
//   reg_write_enable    : register file write strobe
//   reg_write_select    : 0 = alu_result, 1 = mem_read_data
//   state               : current state encoding
//   fault               : sticky error flag, cleared only by reset
//   instr_count         : retired instruction count (wraps)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | waiting for run_enable or step_pulse
// FETCH (1) | reading instruction at PC, waits for mem_ready
// DECODE(2) | one cycle for the control unit to decode
// EXECUTE(3)| ALU cycle; instruction class picks the next state
// MEMORY(4) | load/store access at alu_result, waits for mem_ready
// WRITEBACK(5)| register write and PC update, retires the instruction
// FAULT (7) | memory timeout or illegal class; held until reset
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run_enable,
  input  logic                     step_pulse,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     is_jump,
  core_sequencer_if.master         mem,
  output logic                     ir_load,
  output logic                     pc_enable,
  output logic                     reg_write_enable,
  output logic                     reg_write_select,
  output logic [2:0]               state,
  output logic                     fault,
  output logic [31:0]              instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd7
  } state_t;

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  // The wait cycle that would bring the count to MEM_WAIT_MAX is the one
  // that faults, so the register itself only ever holds 0..MEM_WAIT_MAX-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt;
  // Instruction class is captured in EXECUTE so the MEMORY and WRITEBACK
  // strobes depend only on registered state and mem_ready.
  logic                load_q;
  logic                store_q;
  logic                jump_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      instr_count <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_enable || step_pulse) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.mem_ready) begin
            state_q  <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q  <= S_FAULT;
            fault    <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          load_q  <= is_load;
          store_q <= is_store;
          jump_q  <= is_jump;
          if (is_load && is_store) begin
            state_q <= S_FAULT;
            fault   <= 1'b1;
          end else if (is_load || is_store) begin
            state_q <= S_MEMORY;
          end else begin
            state_q <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (mem.mem_ready) begin
            state_q  <= S_WRITEBACK;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q  <= S_FAULT;
            fault    <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WRITEBACK: begin
          instr_count <= instr_count + 32'd1;
          state_q     <= run_enable ? S_FETCH : S_IDLE;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          // Unused encoding 6 is treated as a fault.
          state_q <= S_FAULT;
          fault   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mem.mem_read_enable  = 1'b0;
    mem.mem_write_enable = 1'b0;
    mem.ifetch_select    = 1'b1;
    ir_load              = 1'b0;
    pc_enable            = 1'b0;
    reg_write_enable     = 1'b0;
    reg_write_select     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_read_enable = 1'b1;
        ir_load             = mem.mem_ready;
      end
      S_MEMORY: begin
        mem.ifetch_select    = 1'b0;
        mem.mem_read_enable  = load_q;
        mem.mem_write_enable = store_q;
      end
      S_WRITEBACK: begin
        pc_enable        = 1'b1;
        // Jumps write the link register; plain stores write nothing.
        reg_write_enable = ~store_q | jump_q;
        reg_write_select = load_q;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
